// File: rtl/pipe_fifo_if.sv
// Ready/valid handshake bundle for pipe_fifo: upstream push side, downstream pop side,
// flush control and status outputs.
interface pipe_fifo_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic [OCC_W-1:0]  count;
  logic [CNT_W-1:0]  stall_cnt;

  // Environment side: drives pushes, pops and flush.
  modport master (
    output flush, i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, count, stall_cnt
  );

  // FIFO side.
  modport slave (
    input  flush, i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, count, stall_cnt
  );
endinterface

// File: rtl/pipe_fifo.sv
// Pipeline buffer with ready/valid on both sides, synchronous flush and a saturating
// stall counter. All handshake outputs depend only on registered occupancy.
module pipe_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input logic        clk,
  input logic        rst_n,
  pipe_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              full, empty, push, pop;

  assign full  = (count_q == OCC_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.i_valid && !full;
  assign pop   = bus.o_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      // Flush wins over any handshake completing on the same edge.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!empty && !bus.o_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage is intentionally not reset; empty slots are masked on o_data.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[wr_ptr_q] <= bus.i_data;
  end

  assign bus.i_ready   = !full;
  assign bus.o_valid   = !empty;
  assign bus.o_data    = empty ? '0 : mem[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.stall_cnt = stall_q;
endmodule

// File: doc/pipe_fifo.md
PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload (e.g. {pc, inst}); legal range 1..256.
REQ-002 Parameter DEPTH, default 2, number of buffered entries; power of two, 2..16.
REQ-003 Parameter CNT_W, default 32, width of the stall counter.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 Port flush  input  1  synchronous discard of all buffered entries.
REQ-007 Port i_valid  input  1  upstream offers i_data.
REQ-008 Port i_ready  output  1  block can accept an entry this cycle.
REQ-009 Port i_data  input  DATA_W  upstream payload.
REQ-010 Port o_valid  output  1  head entry is presented on o_data.
REQ-011 Port o_ready  input  1  downstream accepts head entry.
REQ-012 Port o_data  output  DATA_W  head entry payload.
REQ-013 Port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 Port stall_cnt  output  CNT_W  cycles with o_valid=1 and o_ready=0.

Function
REQ-015 Push occurs when i_valid && i_ready at a rising edge; pop occurs when o_valid && o_ready at a rising edge.
REQ-016 i_ready SHALL equal (count < DEPTH); no combinational path from o_ready or i_valid to i_ready.
REQ-017 o_valid SHALL equal (count != 0); no combinational path from i_valid to o_valid.
REQ-018 Latency: an entry pushed at edge N is presented with o_valid=1 in the cycle following edge N at the earliest.
REQ-019 o_data SHALL equal the oldest unpopped entry while o_valid=1, and all zeros while o_valid=0.
REQ-020 o_data and o_valid SHALL remain stable while o_valid=1 and o_ready=0 (absent flush).
REQ-021 Entries SHALL leave in strict push order; none duplicated, none lost (absent flush).
REQ-022 Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without gaps.
REQ-023 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-024 When full (count=DEPTH), push is impossible (i_ready=0) even if a pop occurs in the same cycle.
REQ-025 When empty, pop is impossible (o_valid=0); a push into an empty buffer sets count to 1.
REQ-026 flush=1 at an edge: count, write pointer and read pointer become 0; any same-edge push or pop is discarded, including a handshake that completed on i_valid/i_ready.
REQ-027 flush SHALL NOT alter stall_cnt.
REQ-028 stall_cnt increments by 1 at each edge where o_valid=1 and o_ready=0, saturates at 2^CNT_W-1, and never wraps.
REQ-029 Storage array contents are not reset; the invalid entries are never observable because of REQ-019.

Reset
REQ-030 While rst_n=0: count=0, o_valid=0, o_data=0, i_ready=1, stall_cnt=0, both pointers=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-032 The first push accepted after rst_n rises SHALL be the first entry popped.

Verification
REQ-033 Fill/drain: DEPTH=2, o_ready=0, push 0x11, 0x22 -> count=2, i_ready=0, o_data=0x11; then o_ready=1 for 2 cycles -> 0x11 then 0x22 popped, count=0, o_valid=0, o_data=0.
REQ-034 Streaming: i_valid=1 and o_ready=1 continuously, data 1..100 -> every value popped exactly once in order, throughput 1/cycle after the first-cycle latency, count stays at 1.
REQ-035 Wrap: DEPTH=4, 10 rounds of push 3 / pop 3 with data 0..29 -> output 0..29 in order, no gap at the pointer wrap.
REQ-036 Flush: count=2, then flush=1 together with i_valid=1 (0xAA) and o_ready=1 -> next cycle count=0, o_valid=0, 0xAA never appears, stall_cnt unchanged.
REQ-037 Stall counter: CNT_W=4, o_valid=1 and o_ready=0 for 20 cycles -> stall_cnt=15 (saturated); rst_n=0 asynchronously -> stall_cnt=0 and o_valid=0 before the next edge.
REQ-038 Random: constrained-random i_valid/o_ready/flush checked against a queue model -> zero mismatches over 100k cycles, including full+pop and empty+push edges.
